dmem_access_unit: RTL and testbench



---
 rtl/dmem_access_unit_pkg.sv | 60 ++++++
 rtl/dmem_access_unit_store_align.sv | 52 +++++
 rtl/dmem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg
// Shared definitions for the memory-stage front end:
//   - FSM state encoding (IDLE/REQ/WAIT/RESP)
//   - LOAD/STORE opcode constants and funct3 codes (LB..LHU, SB..SW)
//   - default data/address width
//   - small decode helpers for load/store classification
package dmem_access_unit_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // True for the five supported load encodings.
  function automatic logic is_load_op(input logic [6:0] opcode, input logic [2:0] funct3);
    logic hit;
    hit = 1'b0;
    if (opcode == OPC_LOAD) begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: hit = 1'b1;
        default:                             hit = 1'b0;
      endcase
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // True for the three supported store encodings.
  function automatic logic is_store_op(input logic [6:0] opcode, input logic [2:0] funct3);
    logic hit;
    hit = 1'b0;
    if (opcode == OPC_STORE) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: hit = 1'b1;
        default:             hit = 1'b0;
      endcase
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dmem_access_unit_store_align.sv
// dmem_access_unit_store_align
// Combinational access-size decode from funct3/byte offset/store data.
// Ports:
//   funct3     in  3       access size in [1:0] (00 byte, 01 half, 10 word)
//   addr_lo    in  2       byte offset within the word
//   wdata      in  DATA_W  raw rs2 value
//   be         out 4       byte enables for the bus
//   wdata_sh   out DATA_W  store data replicated across the byte lanes
//   misaligned out 1       halfword on odd offset or word on non-zero offset
module dmem_access_unit_store_align
  import dmem_access_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic              misaligned
);

  // Size decode: only funct3[1:0] matters, funct3[2] is the load unsigned bit.
  always_comb begin
    be         = 4'b0000;
    wdata_sh   = {DATA_W{1'b0}};
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        wdata_sh   = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        wdata_sh   = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        wdata_sh   = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        be         = 4'b0000;
        wdata_sh   = {DATA_W{1'b0}};
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// Memory-stage front end: accepts one load/store per handshake, checks
// alignment, runs a word-aligned req/gnt/rvalid bus transaction with a
// timeout, and returns the raw word plus instruction/address for extraction.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             execute-stage handshake
//   req_instr/req_addr/req_wdata    instruction, byte address, rs2 value
//   mem_req/we/be/addr/wdata        bus request side (registered)
//   mem_gnt/mem_rvalid/mem_rdata    bus grant and response
//   rsp_valid                       one-cycle completion pulse
//   rsp_memval/instr/addr           held response fields
//   rsp_misaligned/rsp_buserr       exception flags valid with rsp_valid
//   stall                           high while not IDLE
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_instr,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_memval,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [DATA_W-1:0] rsp_addr,
  output logic              rsp_misaligned,
  output logic              rsp_buserr,
  output logic              stall
);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] instr_r;
  logic [DATA_W-1:0] addr_r;
  logic              is_load_r;

  logic              is_load_s;
  logic              is_store_s;
  logic              is_mem_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] wdata_sh_s;
  logic              misal_s;
  logic              tmo_s;
  logic              fin_s;
  logic              tmo_fin_s;

  assign is_load_s  = is_load_op(req_instr[6:0], req_instr[14:12]);
  assign is_store_s = is_store_op(req_instr[6:0], req_instr[14:12]);
  assign is_mem_s   = is_load_s | is_store_s;

  // The counter is about to reach TIMEOUT_CYC on this edge.
  assign tmo_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  dmem_access_unit_store_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (req_instr[14:12]),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .be         (be_s),
    .wdata_sh   (wdata_sh_s),
    .misaligned (misal_s)
  );

  // Completion decode for the bus states; a grant wins over a same-cycle timeout.
  always_comb begin
    fin_s     = 1'b0;
    tmo_fin_s = 1'b0;
    case (state_r)
      ST_REQ: begin
        fin_s     = (mem_gnt & mem_rvalid) | (~mem_gnt & tmo_s);
        tmo_fin_s = ~mem_gnt & tmo_s;
      end
      ST_WAIT: begin
        fin_s     = mem_rvalid | tmo_s;
        tmo_fin_s = ~mem_rvalid & tmo_s;
      end
      default: begin
        fin_s     = 1'b0;
        tmo_fin_s = 1'b0;
      end
    endcase
  end

  // Main FSM with all outputs registered; rsp_* fields change only on entry to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      instr_r        <= {DATA_W{1'b0}};
      addr_r         <= {DATA_W{1'b0}};
      is_load_r      <= 1'b0;
      req_ready      <= 1'b1;
      stall          <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= 4'b0000;
      mem_addr       <= {DATA_W{1'b0}};
      mem_wdata      <= {DATA_W{1'b0}};
      rsp_valid      <= 1'b0;
      rsp_memval     <= {DATA_W{1'b0}};
      rsp_instr      <= {DATA_W{1'b0}};
      rsp_addr       <= {DATA_W{1'b0}};
      rsp_misaligned <= 1'b0;
      rsp_buserr     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            instr_r   <= req_instr;
            addr_r    <= req_addr;
            is_load_r <= is_load_s;
            cnt_r     <= {CNT_W{1'b0}};
            req_ready <= 1'b0;
            stall     <= 1'b1;
            if (is_mem_s && !misal_s) begin
              state_r   <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store_s;
              mem_be    <= be_s;
              mem_addr  <= {req_addr[DATA_W-1:2], 2'b00};
              mem_wdata <= is_store_s ? wdata_sh_s : {DATA_W{1'b0}};
            end else begin
              // Misaligned or non-memory op: answer directly, no bus traffic.
              state_r        <= ST_RESP;
              rsp_valid      <= 1'b1;
              rsp_memval     <= {DATA_W{1'b0}};
              rsp_instr      <= req_instr;
              rsp_addr       <= req_addr;
              rsp_misaligned <= is_mem_s & misal_s;
              rsp_buserr     <= 1'b0;
            end
          end else begin
            req_ready <= 1'b1;
            stall     <= 1'b0;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (fin_s) begin
            state_r        <= ST_RESP;
            mem_req        <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_instr      <= instr_r;
            rsp_addr       <= addr_r;
            rsp_misaligned <= 1'b0;
            rsp_buserr     <= tmo_fin_s;
            rsp_memval     <= (is_load_r && !tmo_fin_s) ? mem_rdata : {DATA_W{1'b0}};
          end else if (state_r == ST_REQ && mem_gnt) begin
            state_r <= ST_WAIT;
            mem_req <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          stall     <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
// Directed self-checking bench for dmem_access_unit (TIMEOUT_CYC=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_dmem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_memval;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_misaligned;
  logic        rsp_buserr;
  logic        stall;

  int n_checks;
  int n_pass;

  localparam logic [31:0] I_LW   = 32'h0000_2003;
  localparam logic [31:0] I_LH   = 32'h0000_1003;
  localparam logic [31:0] I_SB   = 32'h0000_0023;
  localparam logic [31:0] I_SH   = 32'h0000_1023;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;

  dmem_access_unit #(.DATA_W(32), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_instr      (req_instr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_memval     (rsp_memval),
    .rsp_instr      (rsp_instr),
    .rsp_addr       (rsp_addr),
    .rsp_misaligned (rsp_misaligned),
    .rsp_buserr     (rsp_buserr),
    .stall          (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_instr = instr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_instr  = 32'h0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_memval", rsp_memval, 32'd0);

    // LW 0x100: accept cycle, REQ (gnt), WAIT (rvalid), RESP = 4th cycle
    issue(I_LW, 32'h0000_0100, 32'h0);
    check_val("lw_mem_req", {31'd0, mem_req}, 32'd1);
    check_val("lw_mem_addr", mem_addr, 32'h0000_0100);
    check_val("lw_mem_be", {28'd0, mem_be}, 32'hF);
    check_val("lw_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("lw_ready_busy", {31'd0, req_ready}, 32'd0);
    check_val("lw_stall", {31'd0, stall}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check_val("lw_wait_req", {31'd0, mem_req}, 32'd0);
    check_val("lw_wait_rsp", {31'd0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check_val("lw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("lw_memval", rsp_memval, 32'hDEAD_BEEF);
    check_val("lw_rsp_addr", rsp_addr, 32'h0000_0100);
    check_val("lw_rsp_instr", rsp_instr, I_LW);
    check_val("lw_buserr", {31'd0, rsp_buserr}, 32'd0);
    tick();
    check_val("lw_pulse_end", {31'd0, rsp_valid}, 32'd0);
    check_val("lw_memval_hold", rsp_memval, 32'hDEAD_BEEF);
    check_val("lw_idle_ready", {31'd0, req_ready}, 32'd1);

    // SB 0x203 wdata 0xA5
    issue(I_SB, 32'h0000_0203, 32'h0000_00A5);
    check_val("sb_we", {31'd0, mem_we}, 32'd1);
    check_val("sb_be", {28'd0, mem_be}, 32'h8);
    check_val("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_val("sb_addr", mem_addr, 32'h0000_0200);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check_val("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("sb_memval", rsp_memval, 32'd0);
    tick();

    // LH 0x101: misaligned, no bus request, response next cycle
    issue(I_LH, 32'h0000_0101, 32'h0);
    check_val("lh_mis_rsp", {31'd0, rsp_valid}, 32'd1);
    check_val("lh_mis_flag", {31'd0, rsp_misaligned}, 32'd1);
    check_val("lh_mis_req", {31'd0, mem_req}, 32'd0);
    check_val("lh_mis_memval", rsp_memval, 32'd0);
    tick();
    check_val("lh_mis_req2", {31'd0, mem_req}, 32'd0);
    check_val("lh_mis_end", {31'd0, rsp_valid}, 32'd0);

    // LW with no grant: four REQ cycles then bus error
    issue(I_LW, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_val("tmo_req_held", {31'd0, mem_req}, 32'd1);
      check_val("tmo_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check_val("tmo_req_last", {31'd0, mem_req}, 32'd1);
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    check_val("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("tmo_buserr", {31'd0, rsp_buserr}, 32'd1);
    check_val("tmo_memval", rsp_memval, 32'd0);
    check_val("tmo_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check_val("tmo_late_rvalid", {31'd0, rsp_valid}, 32'd0);
    check_val("tmo_late_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check_val("tmo_late_rvalid2", {31'd0, rsp_valid}, 32'd0);

    // SH 0x302 with grant and rvalid together
    issue(I_SH, 32'h0000_0302, 32'h0000_BEEF);
    check_val("sh_be", {28'd0, mem_be}, 32'hC);
    check_val("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check_val("sh_addr", mem_addr, 32'h0000_0300);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check_val("sh_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("sh_buserr", {31'd0, rsp_buserr}, 32'd0);
    check_val("sh_rsp_addr", rsp_addr, 32'h0000_0302);
    tick();

    // Reset while waiting for rvalid
    issue(I_LW, 32'h0000_0040, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check_val("rw_in_wait", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rw_ready", {31'd0, req_ready}, 32'd1);
    check_val("rw_stall", {31'd0, stall}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    check_val("rw_late_rvalid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_val("rw_late_rvalid2", {31'd0, rsp_valid}, 32'd0);

    // Non-memory op: answered next cycle, no flags, no bus traffic
    issue(I_ADDI, 32'h0000_0001, 32'h0);
    check_val("nm_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("nm_misaligned", {31'd0, rsp_misaligned}, 32'd0);
    check_val("nm_buserr", {31'd0, rsp_buserr}, 32'd0);
    check_val("nm_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("nm_instr", rsp_instr, I_ADDI);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
